// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter
// Sits between the datapath and a word-wide data memory. Loads are extracted
// and extended combinationally from the raw read word. SW writes in one cycle.
// SB/SH do a two-cycle read-modify-write and stall the PC for the first cycle.
// Misaligned and out-of-range accesses are blocked. The first one is recorded
// in sticky fault registers.
module lsu_mem_adapter #(
    parameter int MEM_WORDS = 64,
    parameter int AW        = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [2:0]    funct3,
    input  logic [31:0]   addr,
    input  logic [31:0]   store_data,
    output logic [31:0]   load_result,
    output logic          stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_word_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          fault,
    output logic [1:0]    fault_cause,
    output logic [31:0]   fault_addr
);

    typedef enum logic [0:0] {
        IDLE        = 1'b0,
        MERGE_WRITE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   merge_q, merge_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          fault_q, fault_d;
    logic [1:0]    cause_q, cause_d;
    logic [31:0]   faddr_q, faddr_d;

    logic          f3_ok_s, is_byte_s, is_half_s, is_word_s, is_unsigned_s;
    logic          mis_s, oor_s, legal_s, blocked_s;

    // Pick the addressed byte/halfword out of a memory word and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic        is_byte,
                                                 input logic        is_half,
                                                 input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        if (is_byte) begin
            r = {{24{~is_unsigned & b[7]}}, b};
        end else if (is_half) begin
            r = {{16{~is_unsigned & h[15]}}, h};
        end else begin
            r = word;
        end
        return r;
    endfunction

    // Replace the addressed byte/halfword lane of a memory word with store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [1:0]  lane,
                                                input logic        is_byte);
        logic [31:0] r;
        r = word;
        if (is_byte) begin
            case (lane)
                2'd0:    r[7:0]   = data[7:0];
                2'd1:    r[15:8]  = data[7:0];
                2'd2:    r[23:16] = data[7:0];
                default: r[31:24] = data[7:0];
            endcase
        end else if (lane[1]) begin
            r[31:16] = data[15:0];
        end else begin
            r[15:0] = data[15:0];
        end
        return r;
    endfunction

    // Decode the access width and classify the address as legal or blocked.
    always_comb begin
        f3_ok_s       = 1'b0;
        is_byte_s     = 1'b0;
        is_half_s     = 1'b0;
        is_word_s     = 1'b0;
        is_unsigned_s = 1'b0;
        case (funct3)
            3'd0:    begin f3_ok_s = 1'b1; is_byte_s = 1'b1; end
            3'd1:    begin f3_ok_s = 1'b1; is_half_s = 1'b1; end
            3'd2:    begin f3_ok_s = 1'b1; is_word_s = 1'b1; end
            3'd4:    begin f3_ok_s = 1'b1; is_byte_s = 1'b1; is_unsigned_s = 1'b1; end
            3'd5:    begin f3_ok_s = 1'b1; is_half_s = 1'b1; is_unsigned_s = 1'b1; end
            default: f3_ok_s = 1'b0;
        endcase
        mis_s     = (is_half_s & addr[0]) | (is_word_s & (addr[1:0] != 2'b00));
        // Any byte address beyond the last memory word is out of range.
        oor_s     = (addr[31:2] >= 30'(MEM_WORDS));
        legal_s   = req_valid & f3_ok_s & ~mis_s & ~oor_s;
        blocked_s = req_valid & f3_ok_s & (mis_s | oor_s);
    end

    // FSM next state, merge capture and memory-side outputs.
    always_comb begin
        state_d       = state_q;
        merge_d       = merge_q;
        idx_d         = idx_q;
        load_result   = 32'h0000_0000;
        stall         = 1'b0;
        mem_we        = 1'b0;
        mem_word_addr = addr[AW+1:2];
        mem_wdata     = store_data;
        case (state_q)
            IDLE: begin
                if (legal_s && req_write && !is_word_s) begin
                    // Sub-word store: read the word this cycle, write the merge next cycle.
                    stall   = ~rst;
                    state_d = MERGE_WRITE;
                    merge_d = merge_store(mem_rdata, store_data, addr[1:0], is_byte_s);
                    idx_d   = addr[AW+1:2];
                end else if (legal_s && req_write) begin
                    mem_we = ~rst;
                end else if (legal_s) begin
                    load_result = extract_load(mem_rdata, addr[1:0], is_byte_s,
                                               is_half_s, is_unsigned_s);
                end else begin
                    load_result = 32'h0000_0000;
                end
            end
            MERGE_WRITE: begin
                // Inputs are ignored; the held instruction is the one being completed.
                mem_we        = ~rst;
                mem_word_addr = idx_q;
                mem_wdata     = merge_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky fault capture: only the first blocked access is recorded.
    always_comb begin
        fault_d = fault_q;
        cause_d = cause_q;
        faddr_d = faddr_q;
        if ((state_q == IDLE) && blocked_s && !fault_q) begin
            fault_d = 1'b1;
            cause_d = mis_s ? 2'b01 : 2'b10;
            faddr_d = addr;
        end else begin
            fault_d = fault_q;
        end
    end

    // State, merge buffer, captured index and fault registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            merge_q <= 32'h0000_0000;
            idx_q   <= {AW{1'b0}};
            fault_q <= 1'b0;
            cause_q <= 2'b00;
            faddr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            idx_q   <= idx_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            faddr_q <= faddr_d;
        end
    end

    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign fault_addr  = faddr_q;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Testbench for lsu_mem_adapter: a word array stands in for the data memory,
// and a reference model (byte arithmetic over its own copy of memory) predicts
// the outputs of every cycle. A monitor checks them against a queue.
module tb_lsu_mem_adapter;

    localparam int MW = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_write;
    logic [2:0]    funct3;
    logic [31:0]   addr, store_data, load_result, mem_wdata, mem_rdata, fault_addr;
    logic          stall, mem_we, fault;
    logic [AW-1:0] mem_word_addr;
    logic [1:0]    fault_cause;

    always #5 clk = ~clk;

    lsu_mem_adapter #(.MEM_WORDS(MW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .load_result(load_result), .stall(stall), .mem_we(mem_we),
        .mem_word_addr(mem_word_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr)
    );

    // Data memory: asynchronous read, write committed at the rising edge.
    logic [31:0] mem [MW];
    assign mem_rdata = mem[mem_word_addr];
    always @(posedge clk) if (mem_we) mem[mem_word_addr] <= mem_wdata;

    typedef struct packed {
        logic          chk_load;
        logic [31:0]   load;
        logic          stall;
        logic          we;
        logic [AW-1:0] idx;
        logic [31:0]   wdata;
        logic          flt;
        logic [1:0]    cause;
        logic [31:0]   faddr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] ref_mem [MW];
    logic        fault_m = 1'b0;
    logic [1:0]  cause_m = 2'b00;
    logic [31:0] faddr_m = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle for which the stimulus pushed an expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk_load) check("load_result", load_result, mon_e.load);
            check("stall", {31'b0, stall}, {31'b0, mon_e.stall});
            check("mem_we", {31'b0, mem_we}, {31'b0, mon_e.we});
            if (mon_e.we) begin
                check("mem_word_addr", {26'b0, mem_word_addr}, {26'b0, mon_e.idx});
                check("mem_wdata", mem_wdata, mon_e.wdata);
            end
            check("fault", {31'b0, fault}, {31'b0, mon_e.flt});
            check("fault_cause", {30'b0, fault_cause}, {30'b0, mon_e.cause});
            check("fault_addr", fault_addr, mon_e.faddr);
        end
    end

    // One instruction: drive it, predict its outputs from the access rules,
    // push one expectation per cycle it occupies, and update the model.
    task automatic txn(input logic v, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          size, idx, sh;
        bit          f3ok, isu, mis, oor;
        logic [31:0] word, val, mask;
        @(posedge clk); #1;
        req_valid = v; req_write = w; funct3 = f3; addr = a; store_data = d;
        f3ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        isu  = (f3 == 3'd4) || (f3 == 3'd5);
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
        mis  = (a % size) != 0;
        oor  = a >= MW * 4;
        idx  = (a / 4) % MW;
        sh   = 8 * (a % 4);
        e = '0;
        e.flt = fault_m; e.cause = cause_m; e.faddr = faddr_m;
        if (!v || !f3ok) begin
            e.chk_load = 1'b1;
            exp_q.push_back(e);
        end else if (mis || oor) begin
            e.chk_load = 1'b1;
            exp_q.push_back(e);
            if (!fault_m) begin
                fault_m = 1'b1;
                cause_m = mis ? 2'b01 : 2'b10;
                faddr_m = a;
            end
        end else if (!w) begin
            val = ref_mem[idx] >> sh;
            if (size == 1)      val = isu ? (val & 32'hFF)   : {{24{val[7]}}, val[7:0]};
            else if (size == 2) val = isu ? (val & 32'hFFFF) : {{16{val[15]}}, val[15:0]};
            e.chk_load = 1'b1;
            e.load     = val;
            exp_q.push_back(e);
        end else if (size == 4) begin
            e.we = 1'b1; e.idx = AW'(idx); e.wdata = d;
            exp_q.push_back(e);
            ref_mem[idx] = d;
        end else begin
            e.stall = 1'b1;
            exp_q.push_back(e);
            mask = ((size == 1) ? 32'hFF : 32'hFFFF) << sh;
            word = (ref_mem[idx] & ~mask) | ((d << sh) & mask);
            ref_mem[idx] = word;
            @(posedge clk); #1;
            e.stall = 1'b0; e.we = 1'b1; e.idx = AW'(idx); e.wdata = word;
            e.chk_load = 1'b1; e.load = 32'h0;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        logic        v, w;
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;

        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; funct3 = 3'd0;
        addr = 32'h10; store_data = 32'h0;
        #2;
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_cause", {30'b0, fault_cause}, 32'h0);
        check("rst_faddr", fault_addr, 32'h0);
        funct3 = 3'd2;
        #1;
        check("rst_we", {31'b0, mem_we}, 32'h0);
        req_valid = 1'b0;
        #9 rst = 1'b0;

        // Fill memory through the adapter with word stores.
        for (int i = 0; i < MW; i++) txn(1'b1, 1'b1, 3'd2, 32'(i * 4), $urandom);

        // Sub-word loads from a known word.
        txn(1'b1, 1'b1, 3'd2, 32'h14, 32'h8899AABB);
        txn(1'b1, 1'b0, 3'd0, 32'h16, 32'h0);
        txn(1'b1, 1'b0, 3'd4, 32'h16, 32'h0);
        txn(1'b1, 1'b0, 3'd1, 32'h14, 32'h0);
        txn(1'b1, 1'b0, 3'd5, 32'h16, 32'h0);
        // Word store, then read it back.
        txn(1'b1, 1'b1, 3'd2, 32'h20, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
        // Back-to-back byte then halfword read-modify-write.
        txn(1'b1, 1'b1, 3'd2, 32'h0C, 32'h11223344);
        txn(1'b1, 1'b1, 3'd0, 32'h0D, 32'h000000A5);
        txn(1'b1, 1'b1, 3'd1, 32'h0E, 32'h0000BEEF);
        txn(1'b1, 1'b0, 3'd2, 32'h0C, 32'h0);
        // Invalid width code with a store.
        txn(1'b1, 1'b1, 3'd3, 32'h10, 32'h12345678);
        txn(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        // Misaligned load, then an out-of-range store that must not overwrite.
        txn(1'b1, 1'b0, 3'd2, 32'h06, 32'h0);
        txn(1'b1, 1'b1, 3'd2, 32'h400, 32'hCAFEF00D);
        txn(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

        // Reset during the write cycle of a byte store.
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'd0; addr = 32'h25; store_data = 32'h5A;
        exp_q.push_back('{chk_load: 1'b0, load: 32'h0, stall: 1'b1, we: 1'b0, idx: '0,
                          wdata: 32'h0, flt: fault_m, cause: cause_m, faddr: faddr_m});
        @(posedge clk); #1;
        check("merge_we_before_rst", {31'b0, mem_we}, 32'h1);
        rst = 1'b1;
        #1;
        check("merge_we_in_rst", {31'b0, mem_we}, 32'h0);
        check("merge_stall_in_rst", {31'b0, stall}, 32'h0);
        req_valid = 1'b0;
        #1 rst = 1'b0;
        fault_m = 1'b0; cause_m = 2'b00; faddr_m = 32'h0;
        txn(1'b1, 1'b0, 3'd2, 32'h24, 32'h0);
        txn(1'b1, 1'b1, 3'd0, 32'h25, 32'h5A);
        txn(1'b1, 1'b0, 3'd2, 32'h24, 32'h0);

        // Randomized mix of loads, stores, idle and faulting accesses.
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 9) != 0);
            w  = 1'($urandom_range(0, 1));
            f3 = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 19);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(MW * 4 + $urandom_range(0, 1023));
            else             a = 32'($urandom_range(0, MW * 4 - 1));
            txn(v, w, f3, a, $urandom);
        end
        txn(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(posedge clk); @(posedge clk); #1;

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        for (int i = 0; i < MW; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
